// File: rtl/ins_writeback_if.sv
// Execute-to-retire bundle: instruction requests in, register-file and data-memory
// write ports out, plus status back to the upstream stage.
interface ins_writeback_if;
   logic        ex_reg_w_op;
   logic [4:0]  ex_reg_w_reg_idx;
   logic [31:0] ex_reg_w_reg_val;
   logic        ex_mem_w_op;
   logic [31:0] ex_mem_w_mem_addr;
   logic [31:0] ex_mem_w_mem_val;
   logic        rf_w_en;
   logic [4:0]  rf_w_idx;
   logic [31:0] rf_w_val;
   logic        dmem_w_req;
   logic [31:0] dmem_w_addr;
   logic [31:0] dmem_w_data;
   logic        dmem_w_ack;
   logic        wb_busy;
   logic        wb_err_timeout;
   logic        wb_err_overrun;
   logic [31:0] wb_instret;

   // Handshake: the stage accepts an instruction (ex_reg_w_op | ex_mem_w_op) on a
   // posedge only while wb_busy=0; a memory write completes on the posedge where
   // dmem_w_req=1 and dmem_w_ack=1, and addr/data stay stable while req is high.
   modport master (
      output ex_reg_w_op, ex_reg_w_reg_idx, ex_reg_w_reg_val,
             ex_mem_w_op, ex_mem_w_mem_addr, ex_mem_w_mem_val, dmem_w_ack,
      input  rf_w_en, rf_w_idx, rf_w_val, dmem_w_req, dmem_w_addr, dmem_w_data,
             wb_busy, wb_err_timeout, wb_err_overrun, wb_instret
   );

   modport slave (
      input  ex_reg_w_op, ex_reg_w_reg_idx, ex_reg_w_reg_val,
             ex_mem_w_op, ex_mem_w_mem_addr, ex_mem_w_mem_val, dmem_w_ack,
      output rf_w_en, rf_w_idx, rf_w_val, dmem_w_req, dmem_w_addr, dmem_w_data,
             wb_busy, wb_err_timeout, wb_err_overrun, wb_instret
   );
endinterface

// File: rtl/ins_writeback.sv
// Retire stage: pulses register-file writes (skipping x0), runs one memory write at a
// time over req/ack with a timeout, and keeps sticky error flags and a retire count.
module ins_writeback #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TO_CNT_W       = 5
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   ins_writeback_if.slave   bus,
   output logic             o_dbg_state
);

   typedef enum logic {ST_IDLE = 1'b0, ST_MEM = 1'b1} state_t;

   state_t               r_state;
   logic [TO_CNT_W-1:0]  r_to_cnt;
   logic                 r_rf_w_en;
   logic [4:0]           r_rf_w_idx;
   logic [31:0]          r_rf_w_val;
   logic                 r_dmem_w_req;
   logic [31:0]          r_dmem_w_addr;
   logic [31:0]          r_dmem_w_data;
   logic                 r_err_timeout;
   logic                 r_err_overrun;
   logic [31:0]          r_instret;
   logic                 w_in_valid;

   assign w_in_valid = bus.ex_reg_w_op | bus.ex_mem_w_op;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state       <= ST_IDLE;
         r_to_cnt      <= '0;
         r_rf_w_en     <= 1'b0;
         r_rf_w_idx    <= '0;
         r_rf_w_val    <= '0;
         r_dmem_w_req  <= 1'b0;
         r_dmem_w_addr <= '0;
         r_dmem_w_data <= '0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
         r_instret     <= '0;
      end else begin
         r_rf_w_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_in_valid) begin
                  r_instret <= r_instret + 32'd1;
                  if (bus.ex_reg_w_op && (bus.ex_reg_w_reg_idx != 5'd0)) begin
                     r_rf_w_en  <= 1'b1;
                     r_rf_w_idx <= bus.ex_reg_w_reg_idx;
                     r_rf_w_val <= bus.ex_reg_w_reg_val;
                  end
                  if (bus.ex_mem_w_op) begin
                     r_dmem_w_addr <= bus.ex_mem_w_mem_addr;
                     r_dmem_w_data <= bus.ex_mem_w_mem_val;
                     r_dmem_w_req  <= 1'b1;
                     r_to_cnt      <= '0;
                     r_state       <= ST_MEM;
                  end
               end
            end
            ST_MEM: begin
               // A new instruction here is dropped; upstream should have stalled.
               if (w_in_valid) begin
                  r_err_overrun <= 1'b1;
               end
               // Ack takes priority over a timeout landing on the same edge.
               if (bus.dmem_w_ack) begin
                  r_dmem_w_req <= 1'b0;
                  r_state      <= ST_IDLE;
               end else if (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_dmem_w_req  <= 1'b0;
                  r_err_timeout <= 1'b1;
                  r_state       <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rf_w_en        = r_rf_w_en;
   assign bus.rf_w_idx       = r_rf_w_idx;
   assign bus.rf_w_val       = r_rf_w_val;
   assign bus.dmem_w_req     = r_dmem_w_req;
   assign bus.dmem_w_addr    = r_dmem_w_addr;
   assign bus.dmem_w_data    = r_dmem_w_data;
   assign bus.wb_busy        = (r_state != ST_IDLE);
   assign bus.wb_err_timeout = r_err_timeout;
   assign bus.wb_err_overrun = r_err_overrun;
   assign bus.wb_instret     = r_instret;
   assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_ins_writeback.sv
// Bench for ins_writeback: directed cases then random traffic, with a timing model of
// the retire stage and queue-based scoreboards for register and memory writes.
module tb_ins_writeback;
   localparam int T = 4;

   logic sys_clk;
   logic sys_rst;
   logic dbg_state;

   ins_writeback_if bus ();

   ins_writeback #(.TIMEOUT_CYCLES(T), .TO_CNT_W(3)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // ---------------- model state ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  len;
      logic        to;
   } mem_exp_t;

   logic [36:0] exp_q[$];
   mem_exp_t    mem_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_instret = 0;
   bit          exp_overrun = 0;
   int          free_edge = 0;
   int          cur_delay = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int hcnt = 0;
   always @(negedge sys_clk) begin
      if (sys_rst || !bus.dmem_w_req) begin
         hcnt = 0;
         bus.dmem_w_ack = 1'b0;
      end else begin
         hcnt = hcnt + 1;
         bus.dmem_w_ack = (hcnt >= cur_delay);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   bit       in_flight = 0;
   int       hi_len = 0;
   bit       m_timeout = 0;
   mem_exp_t cur;
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         exp_q.delete();
         mem_q.delete();
         in_flight = 0;
         m_timeout = 0;
      end else begin
         if (bus.rf_w_en) begin
            if (exp_q.size() == 0) begin
               chk("rf_unexpected_pulse", {27'd0, bus.rf_w_idx, bus.rf_w_val}, 64'd0);
            end else begin
               logic [36:0] e;
               e = exp_q.pop_front();
               chk("rf_w_idx", bus.rf_w_idx, e[36:32]);
               chk("rf_w_val", bus.rf_w_val, e[31:0]);
            end
         end
         if (bus.dmem_w_req) begin
            if (!in_flight) begin
               if (mem_q.size() == 0) begin
                  chk("dmem_unexpected_req", 1, 0);
                  cur = '0;
               end else begin
                  cur = mem_q.pop_front();
               end
               in_flight = 1;
               hi_len = 0;
            end
            hi_len++;
            chk("dmem_w_addr", bus.dmem_w_addr, cur.addr);
            chk("dmem_w_data", bus.dmem_w_data, cur.data);
         end else if (in_flight) begin
            in_flight = 0;
            m_timeout = m_timeout | cur.to;
            chk("dmem_req_len", hi_len, cur.len);
            chk("wb_err_timeout", bus.wb_err_timeout, m_timeout);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_status();
      chk("wb_instret", bus.wb_instret, exp_instret);
      chk("wb_busy", bus.wb_busy, (cyc + 1 < free_edge));
      chk("wb_err_overrun", bus.wb_err_overrun, exp_overrun);
   endtask

   task automatic issue(input bit r, input logic [4:0] idx, input logic [31:0] val,
                        input bit m, input logic [31:0] a, input logic [31:0] d,
                        input int delay);
      int e;
      int len;
      @(negedge sys_clk);
      bus.ex_reg_w_op       = r;
      bus.ex_reg_w_reg_idx  = idx;
      bus.ex_reg_w_reg_val  = val;
      bus.ex_mem_w_op       = m;
      bus.ex_mem_w_mem_addr = a;
      bus.ex_mem_w_mem_val  = d;
      e = cyc + 1;
      if (r || m) begin
         if (e >= free_edge) begin
            exp_instret++;
            if (r && idx != 0) exp_q.push_back({idx, val});
            if (m) begin
               len = (delay <= T) ? delay : T;
               free_edge = e + len + 1;
               cur_delay = delay;
               mem_q.push_back('{addr: a, data: d, len: 8'(len), to: (delay > T)});
            end
         end else begin
            exp_overrun = 1;
         end
      end
      @(posedge sys_clk);
      #1;
      check_status();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic check_reset_values();
      chk("rst_req", bus.dmem_w_req, 0);
      chk("rst_rf_en", bus.rf_w_en, 0);
      chk("rst_rf_idx", bus.rf_w_idx, 0);
      chk("rst_rf_val", bus.rf_w_val, 0);
      chk("rst_addr", bus.dmem_w_addr, 0);
      chk("rst_data", bus.dmem_w_data, 0);
      chk("rst_timeout", bus.wb_err_timeout, 0);
      chk("rst_overrun", bus.wb_err_overrun, 0);
      chk("rst_instret", bus.wb_instret, 0);
      chk("rst_busy", bus.wb_busy, 0);
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic reset_mid_cycle();
      #1;
      sys_rst = 1'b1;
      bus.ex_reg_w_op = 1'b0;
      bus.ex_mem_w_op = 1'b0;
      #1;
      check_reset_values();
      exp_instret = 0;
      exp_overrun = 0;
      free_edge   = 0;
      @(negedge sys_clk);
      #2 sys_rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      sys_rst = 1'b1;
      bus.ex_reg_w_op = 0; bus.ex_reg_w_reg_idx = 0; bus.ex_reg_w_reg_val = 0;
      bus.ex_mem_w_op = 0; bus.ex_mem_w_mem_addr = 0; bus.ex_mem_w_mem_val = 0;
      bus.dmem_w_ack = 0;
      repeat (3) @(posedge sys_clk);
      #1;
      check_reset_values();
      @(negedge sys_clk);
      #2 sys_rst = 1'b0;

      // single register write
      issue(1, 5, 32'hDEADBEEF, 0, 0, 0, 1);
      idle(2);
      // x0 suppression, back to back
      issue(1, 0, 32'h1111_0000, 0, 0, 0, 1);
      issue(1, 1, 32'h2222_0001, 0, 0, 0, 1);
      issue(1, 0, 32'h3333_0000, 0, 0, 0, 1);
      idle(2);
      // memory write, ack after 3 cycles
      issue(0, 0, 0, 1, 32'h100, 32'h55AA, 3);
      idle(6);
      // ack on the timeout edge, then an immediate ack, then both ops together
      issue(0, 0, 0, 1, 32'h200, 32'hA5A5_0001, T);
      idle(T + 2);
      issue(0, 0, 0, 1, 32'h204, 32'hA5A5_0002, 1);
      idle(3);
      issue(1, 9, 32'h0909_0909, 1, 32'h208, 32'hA5A5_0003, 2);
      idle(4);
      // timeout, then a successful write while the flag stays set
      issue(0, 0, 0, 1, 32'h300, 32'hBAD0_0001, 50);
      idle(T + 2);
      issue(0, 0, 0, 1, 32'h304, 32'h600D_0001, 2);
      idle(4);
      // overrun: register write while busy is dropped
      issue(0, 0, 0, 1, 32'h400, 32'h0000_0400, 3);
      issue(1, 7, 32'h7777_7777, 0, 0, 0, 1);
      idle(6);
      // async reset mid-handshake, then normal operation
      issue(0, 0, 0, 1, 32'h500, 32'h0000_0500, 50);
      idle(1);
      reset_mid_cycle();
      issue(1, 3, 32'h0303_0303, 1, 32'h504, 32'h0000_0504, 2);
      idle(5);

      // random traffic
      for (int i = 0; i < 250; i++) begin
         bit r;
         bit m;
         logic [4:0] idx;
         if ($urandom_range(0, 3) != 0) begin
            while (cyc + 1 < free_edge) idle(1);
         end
         r   = 1'($urandom_range(0, 1));
         m   = ($urandom_range(0, 2) == 0);
         idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         issue(r, idx, $urandom, m, $urandom, $urandom, $urandom_range(1, T + 2));
      end
      idle(T + 4);

      chk("rf_queue_drained", exp_q.size(), 0);
      chk("mem_queue_drained", mem_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule

// File: doc/ins_writeback.md
Name: ins_writeback

Overview:
- Retire stage directly downstream of the execute stage.
- Consumes the execute stage's per-instruction register-write and memory-write requests.
- Register writes go to the register-file write port, skipping x0.
- Memory writes go to the data-memory write port over a req/ack handshake with a timeout.
- Provides a busy/stall indication back upstream, sticky error flags and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles dmem_w_req stays high without dmem_w_ack before abort (>=1).
- TO_CNT_W, 5, width of timeout counter; must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- sys_clk  in  1  single clock; all state on posedge.
- sys_rst  in  1  asynchronous, active-high reset.
- ex_reg_w_op  in  1  execute stage requests register write.
- ex_reg_w_reg_idx  in  5  destination register index.
- ex_reg_w_reg_val  in  32  destination value.
- ex_mem_w_op  in  1  execute stage requests memory write.
- ex_mem_w_mem_addr  in  32  memory write address.
- ex_mem_w_mem_val  in  32  memory write data.
- rf_w_en  out  1  register-file write strobe, 1-cycle pulse.
- rf_w_idx  out  5  register-file write index.
- rf_w_val  out  32  register-file write data.
- dmem_w_req  out  1  data-memory write request.
- dmem_w_addr  out  32  held stable while dmem_w_req=1.
- dmem_w_data  out  32  held stable while dmem_w_req=1.
- dmem_w_ack  in  1  memory accepts write; sampled on posedge.
- wb_busy  out  1  stage cannot accept a new instruction; combinational from state.
- wb_err_timeout  out  1  sticky: a memory write was aborted.
- wb_err_overrun  out  1  sticky: a request arrived while busy.
- wb_instret  out  32  retired-instruction count, wraps at 2^32.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All outputs 0: rf_w_en, rf_w_idx, rf_w_val, dmem_w_req, dmem_w_addr, dmem_w_data, wb_err_timeout, wb_err_overrun, wb_instret.
  - Timeout counter=0.
  - Reset mid-handshake drops dmem_w_req at once; no write is retried.
- Request definition: in_valid = ex_reg_w_op | ex_mem_w_op, sampled on posedge.
- wb_busy = (state != IDLE).
- Accept condition: posedge with in_valid=1 and state=IDLE. On accept:
  - wb_instret += 1.
  - If ex_reg_w_op=1 and idx!=0: next cycle rf_w_en=1 with the captured idx/val, for exactly one cycle.
  - If ex_reg_w_op=1 and idx=0: rf_w_en stays 0; the instruction still counts as retired.
  - If ex_mem_w_op=1: capture addr/data into dmem_w_addr/dmem_w_data, set dmem_w_req=1, clear the timeout counter, go to MEM.
- Latencies:
  - Register-only instruction: 1 cycle accept-to-rf_w_en; state stays IDLE, so back-to-back register writes run every cycle.
  - Instruction with both ops: rf_w_en pulse and dmem_w_req rise in the same cycle.
- rf_w_idx/rf_w_val hold their last values when rf_w_en=0.
- MEM state, each posedge:
  - dmem_w_ack=1: dmem_w_req->0 next cycle, go to IDLE. Minimum occupancy is 1 cycle when ack is already high on the first sampled edge.
  - Else, counter==TIMEOUT_CYCLES-1: dmem_w_req->0, wb_err_timeout->1, go to IDLE.
  - Else: counter += 1; req, addr and data held.
  - Ack on the same edge the timeout would fire: ack wins, no error.
- Overrun: in_valid=1 while state=MEM:
  - Request discarded, no retire.
  - wb_err_overrun->1 (sticky).
  - Upstream must stall on wb_busy.
- The sticky flags clear only on sys_rst.
- No combinational path from ex_* inputs to any output.

Test Plan:
- Reg write: ex_reg_w_op=1, idx=5, val=0xDEADBEEF for one cycle -> next cycle rf_w_en=1, rf_w_idx=5, rf_w_val=0xDEADBEEF; wb_instret=1; wb_busy stays 0.
- x0 suppress: 3 back-to-back reg writes with idx=0,1,0 -> rf_w_en pulses once (idx=1); wb_instret=3.
- Mem write with ack delay 3: addr=0x100, data=0x55AA -> dmem_w_req high for exactly 3 cycles, addr/data stable throughout, wb_busy high for 3 cycles, then IDLE; wb_err_timeout=0.
- Timeout, TIMEOUT_CYCLES=4, ack never arrives -> req high for 4 cycles then low; wb_err_timeout=1 and persists across a subsequent successful write.
- Overrun: issue a mem write, then a reg write (idx=7) while busy -> no rf_w_en for idx 7; wb_err_overrun=1; wb_instret counts 1 only.
- Async reset mid-MEM: assert sys_rst between clock edges while dmem_w_req=1 -> req, flags and wb_instret go to 0 immediately; after release, a new write is accepted normally.
